// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
// Helpers work on a fixed maximum width so that every instance size can
// share them; callers widen their N-bit vectors on the way in and trim
// the results on the way out.
package rr_arb_pkg;

  localparam int MAX_N  = 32;
  localparam int MAX_NW = 5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  // Index of the first set request found by starting at the token bit and
  // walking upward, wrapping from n-1 back to 0. Returns 0 when nothing is set.
  function automatic int unsigned first_from(input logic [MAX_N-1:0] req,
                                             input logic [MAX_N-1:0] token,
                                             input int unsigned      n);
    int unsigned start;
    int unsigned idx;
    int unsigned result;
    logic        found;
    start  = 0;
    result = 0;
    found  = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (token[i[MAX_NW-1:0]]) start = i;
    end
    for (int unsigned k = 0; k < MAX_N; k++) begin
      if (k < n && !found) begin
        idx = (start + k) % n;
        if (req[idx[MAX_NW-1:0]]) begin
          result = idx;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    logic [MAX_N-1:0] v;
    v = '0;
    v[idx[MAX_NW-1:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Requester-side bundle of the ring arbiter: request lines in, grant and
// status out. The arbiter uses the slave view, requesters the master view.
interface rr_ring_arbiter_if #(
  parameter int N = 4
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           expired;
  logic [N-1:0]   token;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  expired,
    input  token
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output expired,
    output token
  );

endinterface

// File: rtl/rr_token_ring.sv
// One-hot priority pointer. It sits at bit 0 out of reset and only moves
// when the arbiter loads the slot just after a new winner, so it never
// becomes zero or multi-hot.
module rr_token_ring #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] token
);

  localparam logic [N-1:0] TOKEN_INIT = N'(1);

  // Hold the pointer, or take the rotated winner position when told to.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      token <= TOKEN_INIT;
    end else if (load) begin
      token <= load_value;
    end
  end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter for one shared resource. A grant is held until the
// owner drops its request or the hold limit runs out, then the resource
// sits idle for a fixed dead gap before anyone else may win it.
module rr_ring_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset_,
  rr_ring_arbiter_if.slave   bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int GCW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_ONE   = HCW'(1);
  localparam logic [GCW-1:0] GAP_LIMIT  = GCW'(GAP_CYCLES);
  localparam logic [GCW-1:0] GAP_ONE    = GCW'(1);

  arb_state_t     state;
  logic [HCW-1:0] hold_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [N-1:0]   grant_r;
  logic [IDW-1:0] grant_id_r;
  logic           busy_r;
  logic           expired_r;
  logic [N-1:0]   token;

  int unsigned    winner;
  logic [N-1:0]   winner_oh;
  logic [N-1:0]   next_token;
  logic           token_load;
  logic           owner_req;
  logic           hold_done;

  // Pick the next owner from the token position and work out the decisions
  // the state machine needs this cycle.
  always_comb begin
    winner     = first_from(MAX_N'(bus.req), MAX_N'(token), N);
    winner_oh  = N'(onehot(winner));
    next_token = N'(onehot((winner + 1) % N));
    token_load = (state == ARB_IDLE) && (bus.req != '0);
    owner_req  = bus.req[grant_id_r];
    hold_done  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIMIT);
  end

  rr_token_ring #(
    .N (N)
  ) u_token_ring (
    .clock      (clock),
    .reset_     (reset_),
    .load       (token_load),
    .load_value (next_token),
    .token      (token)
  );

  // Arbitration state machine with registered grant and status outputs.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state      <= ARB_IDLE;
      grant_r    <= '0;
      grant_id_r <= '0;
      busy_r     <= 1'b0;
      expired_r  <= 1'b0;
      hold_cnt   <= '0;
      gap_cnt    <= '0;
    end else begin
      expired_r <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (bus.req != '0) begin
            state      <= ARB_BUSY;
            grant_r    <= winner_oh;
            grant_id_r <= IDW'(winner);
            busy_r     <= 1'b1;
            hold_cnt   <= HOLD_ONE;
          end
        end
        ARB_BUSY: begin
          // A release on the same edge the limit is reached counts as
          // voluntary, so expired only fires while the owner still wants it.
          if (!owner_req || hold_done) begin
            state      <= ARB_GAP;
            grant_r    <= '0;
            grant_id_r <= '0;
            busy_r     <= 1'b0;
            gap_cnt    <= GAP_ONE;
            expired_r  <= owner_req && hold_done;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        ARB_GAP: begin
          if (gap_cnt == GAP_LIMIT) begin
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = grant_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;
  assign bus.expired  = expired_r;
  assign bus.token    = token;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Bench for the ring arbiter: a fixed vector table, a few hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
// Two instances share clock and reset: one with a hold limit of 8 and one
// with no limit.
module tb_rr_ring_arbiter;

  localparam int N   = 4;
  localparam int GAP = 1;

  localparam int P_IDLE = 0;
  localparam int P_BUSY = 1;
  localparam int P_GAP  = 2;

  logic clock = 1'b0;
  logic reset_;

  always #5 clock = ~clock;

  rr_ring_arbiter_if #(.N(N)) bus8 ();
  rr_ring_arbiter_if #(.N(N)) bus0 ();

  rr_ring_arbiter #(
    .N          (N),
    .MAX_HOLD   (8),
    .GAP_CYCLES (GAP)
  ) dut8 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus8)
  );

  rr_ring_arbiter #(
    .N          (N),
    .MAX_HOLD   (0),
    .GAP_CYCLES (GAP)
  ) dut0 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus0)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: which phase we are in, who owns the resource, how
  // long it has held it, and the priority pointer as a plain index.
  typedef struct {
    int   phase;
    int   owner;
    int   hold;
    int   gap;
    int   tok;
    logic expired;
  } model_t;

  model_t m8;
  model_t m0;

  function automatic model_t model_reset();
    model_t r;
    r.phase   = P_IDLE;
    r.owner   = 0;
    r.hold    = 0;
    r.gap     = 0;
    r.tok     = 0;
    r.expired = 1'b0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic rst_n,
                                        input logic [3:0] req, input int max_hold);
    model_t n;
    n = m;
    n.expired = 1'b0;
    if (!rst_n) begin
      n = model_reset();
    end else if (m.phase == P_IDLE) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m.tok + k) % N;
        if (req[idx] && n.phase == P_IDLE) begin
          n.phase = P_BUSY;
          n.owner = idx;
          n.hold  = 1;
          n.tok   = (idx + 1) % N;
        end
      end
    end else if (m.phase == P_BUSY) begin
      if (!req[m.owner]) begin
        n.phase = P_GAP;
        n.gap   = 1;
      end else if (max_hold != 0 && m.hold == max_hold) begin
        n.phase   = P_GAP;
        n.gap     = 1;
        n.expired = 1'b1;
      end else begin
        n.hold = m.hold + 1;
      end
    end else begin
      if (m.gap == GAP) n.phase = P_IDLE;
      else n.gap = m.gap + 1;
    end
    return n;
  endfunction

  // Expected {grant, grant_id, busy, expired, token} for a model state.
  function automatic logic [11:0] model_outputs(input model_t m);
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    b  = (m.phase == P_BUSY);
    g  = b ? 4'(1 << m.owner) : 4'b0000;
    id = b ? 2'(m.owner) : 2'd0;
    return {g, id, b, m.expired, 4'(1 << m.tok)};
  endfunction

  // Advance both models on every rising edge with the inputs the DUTs see.
  always @(posedge clock) begin
    m8 = model_step(m8, reset_, bus8.req, 8);
    m0 = model_step(m0, reset_, bus0.req, 0);
  end

  task automatic checkOutput(input string name, input logic [11:0] got, input logic [11:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic checkModels();
    checkOutput("model8", {bus8.grant, bus8.grant_id, bus8.busy, bus8.expired, bus8.token},
                model_outputs(m8));
    checkOutput("model0", {bus0.grant, bus0.grant_id, bus0.busy, bus0.expired, bus0.token},
                model_outputs(m0));
    checkOutput("onehot8", {11'd0, $onehot(bus8.token) && $onehot0(bus8.grant)}, 12'd1);
    checkOutput("onehot0", {11'd0, $onehot(bus0.token) && $onehot0(bus0.grant)}, 12'd1);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, then check
  // both instances against the model at the next falling edge.
  task automatic applyStimulus(input logic rst_n, input logic [3:0] r8, input logic [3:0] r0);
    reset_   = rst_n;
    bus8.req = r8;
    bus0.req = r0;
    @(posedge clock);
    @(negedge clock);
    checkModels();
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [11:0] want;
  } vec_t;

  vec_t vec_q[$];

  function automatic void add(input logic rst_n, input logic [3:0] req, input logic [3:0] g,
                              input logic [1:0] id, input logic b, input logic e,
                              input logic [3:0] tok);
    vec_t v;
    v.rst_n = rst_n;
    v.req   = req;
    v.want  = {g, id, b, e, tok};
    vec_q.push_back(v);
  endfunction

  initial begin
    logic [3:0] cur8;
    logic [3:0] cur0;
    logic [3:0] exp_g;
    logic       rst_n;

    reset_   = 1'b0;
    bus8.req = 4'b0000;
    bus0.req = 4'b0000;
    m8 = model_reset();
    m0 = model_reset();

    // Reset, single requester, wrap-around search, release exactly at the
    // hold limit, and reset in the middle of a grant.
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001);
    add(0, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0001);
    add(1, 4'b0100, 4'b0100, 2, 1, 0, 4'b1000);
    add(1, 4'b0100, 4'b0100, 2, 1, 0, 4'b1000);
    add(1, 4'b0100, 4'b0100, 2, 1, 0, 4'b1000);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b1000);
    add(1, 4'b0011, 4'b0000, 0, 0, 0, 4'b1000);
    add(1, 4'b0011, 4'b0001, 0, 1, 0, 4'b0010);
    add(1, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010);
    add(1, 4'b0010, 4'b0000, 0, 0, 0, 4'b0010);
    add(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0100);
    for (int i = 0; i < 7; i++) add(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100);
    add(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0100);
    for (int i = 0; i < 4; i++) add(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0100);
    add(0, 4'b0010, 4'b0000, 0, 0, 0, 4'b0001);
    add(1, 4'b0010, 4'b0010, 1, 1, 0, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100);
    add(1, 4'b0000, 4'b0000, 0, 0, 0, 4'b0100);

    @(negedge clock);
    for (int i = 0; i < vec_q.size(); i++) begin
      applyStimulus(vec_q[i].rst_n, vec_q[i].req, 4'b0000);
      checkOutput($sformatf("vec%0d", i),
                  {bus8.grant, bus8.grant_id, bus8.busy, bus8.expired, bus8.token},
                  vec_q[i].want);
    end

    // All four requesting forever: 0,1,2,3,0, eight cycles each, expiry
    // pulse then one more low cycle between owners.
    applyStimulus(0, 4'b0000, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'(1 << (g % N));
      for (int c = 0; c < 8; c++) begin
        applyStimulus(1, 4'b1111, 4'b0000);
        checkOutput($sformatf("rr_grant%0d_c%0d", g, c), {7'd0, bus8.grant, bus8.expired},
                    {7'd0, exp_g, 1'b0});
      end
      applyStimulus(1, 4'b1111, 4'b0000);
      checkOutput($sformatf("rr_expire%0d", g), {7'd0, bus8.grant, bus8.expired},
                  {7'd0, 4'b0000, 1'b1});
      applyStimulus(1, 4'b1111, 4'b0000);
      checkOutput($sformatf("rr_gap%0d", g), {7'd0, bus8.grant, bus8.expired},
                  {7'd0, 4'b0000, 1'b0});
    end

    // Without a hold limit a single owner keeps the grant indefinitely.
    applyStimulus(0, 4'b0000, 4'b0000);
    applyStimulus(1, 4'b0000, 4'b0000);
    for (int c = 0; c < 50; c++) begin
      applyStimulus(1, 4'b0000, 4'b0001);
      checkOutput($sformatf("nolimit_c%0d", c), {7'd0, bus0.grant, bus0.expired},
                  {7'd0, 4'b0001, 1'b0});
    end

    // Randomized traffic with requests that persist for a while and the
    // occasional reset, checked against the model every cycle.
    cur8 = 4'b0000;
    cur0 = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) cur8 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) cur0 = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(rst_n, cur8, cur0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
